// File: rtl/spi_frame_pkg.sv
// Shared types and sizing helpers for the SPI frame slave.
//   state_e        : frame FSM states
//   FRAME_BITS_DEF : default frame length in bits
//   cnt_w()        : bit-counter width able to hold 0..frame_bits inclusive
package spi_frame_pkg;

  localparam int unsigned FRAME_BITS_DEF = 256;

  typedef enum logic [1:0] {
    StWait,
    StIdle,
    StShift,
    StOverrun
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned frame_bits);
    return $clog2(frame_bits + 1);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_w(FRAME_BITS_DEF);

endpackage

// File: rtl/spi_frame_slave_if.sv
// Bundle of SPI pins and frame-side data between the SPI frame slave and its surroundings.
//   spi_sclk/spi_cs_n/spi_mosi : SPI pins from the master (mode 0)
//   spi_miso                   : SPI data back to the master
//   tx_data                    : frame to send, snapshotted at frame start
//   rx_data/rx_valid           : last good received frame and its update pulse
//   frame_err                  : pulse on short or overlong frame
//   busy                       : frame in progress (SHIFT or OVERRUN)
//   wdog_trip                  : watchdog tripped (only with SPI_WATCHDOG_EN)
// Modports: slave (the transceiver), master (SPI master / frame packers).
interface spi_frame_slave_if
  import spi_frame_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF
) ();

  logic                  spi_sclk;
  logic                  spi_cs_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [FRAME_BITS-1:0] tx_data;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_err;
  logic                  busy;
  logic                  wdog_trip;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, tx_data,
    output spi_miso, rx_data, rx_valid, frame_err, busy, wdog_trip
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, tx_data,
    input  spi_miso, rx_data, rx_valid, frame_err, busy, wdog_trip
  );

endinterface

// File: rtl/spi_in_sync.sv
// Synchronizer for one asynchronous SPI pin plus registered edge strobes.
//   clk, rst_n : system clock, async active-low reset
//   d_i        : raw pin
//   q_o        : synchronized level, aligned with rise_o/fall_o
//   rise_o     : one-cycle strobe on a 0->1 transition
//   fall_o     : one-cycle strobe on a 1->0 transition
// SYNC_STAGES must be >= 2. RESET_VAL is the idle level of the pin.
module spi_in_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  // Stages [SYNC_STAGES-1:0] synchronize; the extra top stage is the edge-detect history
  // and doubles as the level output so level and strobes line up in the same cycle.
  logic [SYNC_STAGES:0] chain_q, chain_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-1:0], d_i};
    rise_d  = chain_q[SYNC_STAGES-1] & ~chain_q[SYNC_STAGES];
    fall_d  = ~chain_q[SYNC_STAGES-1] & chain_q[SYNC_STAGES];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {(SYNC_STAGES + 1){RESET_VAL}};
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q_o    = chain_q[SYNC_STAGES];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave frame transceiver, fully in the clk domain (SPI pins are oversampled).
//   clk, rst_n : system clock (SCLK <= clk/8), async active-low reset
//   bus        : spi_frame_slave_if.slave (SPI pins, tx/rx frames, status pulses)
// Bit 0 goes first on both MOSI and MISO; MOSI bit k lands in rx_data[k].
// A full frame updates rx_data with a one-cycle rx_valid; short or overlong frames pulse
// frame_err and leave rx_data alone.
// Optional macro SPI_WATCHDOG_EN: after WDOG_CYCLES clk without rx_valid, rx_data is forced
// to 0 and wdog_trip is held until the next good frame. Without it wdog_trip is tied 0.
module spi_frame_slave
  import spi_frame_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDOG_CYCLES = 5000000
) (
  input logic              clk,
  input logic              rst_n,
  spi_frame_slave_if.slave bus
);

  localparam int unsigned      CNT_W    = cnt_w(FRAME_BITS);
  localparam int unsigned      IDX_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] SETTLE   = CNT_W'(SYNC_STAGES + 2);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_rise, cs_fall, cs_lvl;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.spi_sclk),
    .q_o    (sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.spi_cs_n),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (bus.spi_mosi),
    .q_o    (mosi_lvl),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_load;
  logic [IDX_W-1:0]      idx;

  assign idx = cnt_q[IDX_W-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_load     = 1'b0;

    // cs_rise takes priority over everything, including a same-cycle sclk_rise.
    if (cs_rise) begin
      state_d = StIdle;
      miso_d  = 1'b0;
      if (state_q == StShift && cnt_q == CNT_FULL) begin
        rx_load    = 1'b1;
        rx_valid_d = 1'b1;
      end else if (state_q == StShift || state_q == StOverrun) begin
        frame_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        // The counter doubles as a settle timer: the CS_N chain resets to 1, so with the pin
        // held low a stale cs_fall appears shortly after reset and must not start a frame.
        StWait: begin
          miso_d = 1'b0;
          if (cnt_q != SETTLE) begin
            cnt_d = cnt_q + 1'b1;
          end else if (cs_lvl) begin
            state_d = StIdle;
          end
        end
        StIdle: begin
          miso_d = 1'b0;
          if (cs_fall) begin
            tx_shift_d = bus.tx_data;
            miso_d     = bus.tx_data[0];
            cnt_d      = '0;
            state_d    = StShift;
          end
        end
        StShift: begin
          if (sclk_rise) begin
            if (cnt_q == CNT_FULL) begin
              state_d = StOverrun;
              miso_d  = 1'b0;
            end else begin
              rx_shift_d[idx] = mosi_lvl;
              cnt_d           = cnt_q + 1'b1;
            end
          end else if (sclk_fall && cnt_q < CNT_FULL) begin
            miso_d = tx_shift_q[idx];
          end
        end
        StOverrun: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = StWait;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StWait;
      cnt_q       <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SPI_WATCHDOG_EN
  localparam int unsigned       WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_trip_q, wdog_trip_d;
  logic              wdog_hit;

  // A frame loading in the same cycle wins over the safe-state clear; the rx_valid that
  // follows then restarts the counter.
  always_comb begin
    wdog_hit    = (wdog_cnt_q == WDOG_LAST) && !rx_valid_q && !rx_load;
    wdog_cnt_d  = wdog_cnt_q;
    wdog_trip_d = wdog_trip_q;
    if (rx_valid_q) begin
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
    end else if (wdog_cnt_q != WDOG_LAST) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end else if (wdog_hit) begin
      wdog_trip_d = 1'b1;
    end

    if (rx_load) begin
      rx_data_d = rx_shift_q;
    end else if (wdog_hit) begin
      rx_data_d = '0;
    end else begin
      rx_data_d = rx_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign bus.wdog_trip = wdog_trip_q;
`else
  logic unused_wdog_cycles;
  assign unused_wdog_cycles = ^WDOG_CYCLES;

  always_comb begin
    rx_data_d = rx_load ? rx_shift_q : rx_data_q;
  end

  assign bus.wdog_trip = 1'b0;
`endif

  assign bus.spi_miso  = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q == StShift) || (state_q == StOverrun);

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: good, short, overlong, TX change and mid-frame reset.
module tb_spi_frame_slave;

  localparam logic [255:0] TX1 = {32{8'hA5}};
  localparam logic [255:0] TX2 = {16{16'h3C96}};
  localparam logic [255:0] RX1 = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] RX2 = {4{64'hFEDCBA9876543210}};
  localparam logic [255:0] RX3 = {8{32'hDEADBEEF}};
  localparam logic [255:0] RX4 = {4{64'h5555AAAA33CC0FF0}};

  logic clk = 1'b0;
  logic rst_n;

  spi_frame_slave_if #(.FRAME_BITS(256)) bus ();

  spi_frame_slave #(
    .FRAME_BITS  (256),
    .SYNC_STAGES (2),
    .WDOG_CYCLES (1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_cnt   = 0;
  int fe_cnt   = 0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rv_cnt++;
    if (bus.frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [259:0] obs, input logic [259:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [259:0] miso_cap;
  logic         busy_mid;
  logic         busy_last;

  task automatic half_period();
    repeat (4) @(negedge clk);
  endtask

  // Mode-0 master: MOSI changes while SCLK is low, MISO is sampled just before SCLK rises.
  task automatic xfer(input int nbits, input logic [255:0] mosi, input int tx_chg_bit,
                      input int rst_bit);
    miso_cap = '0;
    bus.spi_cs_n = 1'b0;
    half_period();
    for (int i = 0; i < nbits; i++) begin
      if (i == tx_chg_bit) bus.tx_data = '0;
      if (i == rst_bit) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      bus.spi_mosi = (i < 256) ? mosi[i] : 1'b1;
      half_period();
      miso_cap[i] = bus.spi_miso;
      bus.spi_sclk = 1'b1;
      half_period();
      if (i == nbits / 2) busy_mid = bus.busy;
      if (i == nbits - 1) busy_last = bus.busy;
      bus.spi_sclk = 1'b0;
    end
    half_period();
    bus.spi_cs_n = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rx_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  int rv0, fe0, lat;

  initial begin
    rst_n        = 1'b0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = TX1;
    repeat (3) @(negedge clk);
    check("reset miso", bus.spi_miso, 0);
    check("reset rx_data", bus.rx_data, 0);
    check("reset rx_valid", bus.rx_valid, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset busy", bus.busy, 0);
    check("reset wdog_trip", bus.wdog_trip, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle busy", bus.busy, 0);

    // Good frame
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(256, RX1, -1, -1);
    wait_valid(lat);
    check("rx_valid latency", lat, 4);
    repeat (8) @(negedge clk);
    check("good miso stream", miso_cap[255:0], TX1);
    check("good rx_data", bus.rx_data, RX1);
    check("good rx_valid count", rv_cnt - rv0, 1);
    check("good frame_err count", fe_cnt - fe0, 0);
    check("good busy mid", busy_mid, 1);
    check("good busy after", bus.busy, 0);
    check("good miso after", bus.spi_miso, 0);

`ifdef SPI_WATCHDOG_EN
    check("wdog clear after frame", bus.wdog_trip, 0);
    repeat (1005) @(negedge clk);
    check("wdog rx_data safe", bus.rx_data, 0);
    check("wdog trip set", bus.wdog_trip, 1);
    xfer(256, RX2, -1, -1);
    repeat (12) @(negedge clk);
    check("wdog trip cleared", bus.wdog_trip, 0);
    check("wdog next rx_data", bus.rx_data, RX2);
`else
    // TX_DATA dropped to 0 at bit 100: snapshot must still go out
    bus.tx_data = TX2;
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(256, RX2, 100, -1);
    repeat (12) @(negedge clk);
    check("txchg miso stream", miso_cap[255:0], TX2);
    check("txchg rx_data", bus.rx_data, RX2);
    check("txchg rx_valid count", rv_cnt - rv0, 1);
    check("txchg frame_err count", fe_cnt - fe0, 0);

    // Short frame
    bus.tx_data = TX1;
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(255, RX3, -1, -1);
    repeat (12) @(negedge clk);
    check("short frame_err count", fe_cnt - fe0, 1);
    check("short rx_valid count", rv_cnt - rv0, 0);
    check("short rx_data kept", bus.rx_data, RX2);

    // Overlong frame
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(260, RX4, -1, -1);
    repeat (12) @(negedge clk);
    check("over miso tail", miso_cap[259:257], 0);
    check("over busy mid", busy_mid, 1);
    check("over busy last", busy_last, 1);
    check("over frame_err count", fe_cnt - fe0, 1);
    check("over rx_valid count", rv_cnt - rv0, 0);
    check("over rx_data kept", bus.rx_data, RX2);

    // Reset at bit 128 with CS_N held low, master finishes the frame
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(256, RX3, -1, 128);
    repeat (12) @(negedge clk);
    check("rstmid rx_valid count", rv_cnt - rv0, 0);
    check("rstmid frame_err count", fe_cnt - fe0, 0);
    check("rstmid rx_data", bus.rx_data, 0);
    rv0 = rv_cnt; fe0 = fe_cnt;
    xfer(256, RX1, -1, -1);
    repeat (12) @(negedge clk);
    check("post-rst rx_data", bus.rx_data, RX1);
    check("post-rst rx_valid count", rv_cnt - rv0, 1);
    check("post-rst frame_err count", fe_cnt - fe0, 0);
    check("post-rst miso stream", miso_cap[255:0], TX1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
